btb_tag_array: RTL and testbench

Parametrised tag store for the branch target buffer: a WAYS-way, SETS-set associative array of PC tags with per-entry valid bits, an internal replacement policy and a multi-cycle flush sequencer. Lookups return a registered hit/way one cycle after the request. Fills choose their own victim way, and the companion target array consumes that choice on the same edge. The block sits in the fetch stage beside the BTB target array and the predictor counters.

---
 rtl/btb_tag_array_pkg.sv | 25 ++
 rtl/btb_tag_array_if.sv | 46 ++++
 rtl/btb_tag_array_plru.sv | 80 ++++++++
 rtl/btb_tag_array.sv | 211 +++++++++++++++++++++
 tb/tb_btb_tag_array.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/btb_tag_array_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btb_tag_array_pkg
// Description : Shared types and default sizes for the BTB tag store and the
//               blocks that instantiate it.
// Revision    : 1.0 - initial release
// ============================================================================
package btb_tag_array_pkg;

    // Default geometry used by instantiating blocks
    localparam int BTB_WAYS  = 4;
    localparam int BTB_SETS  = 16;
    localparam int BTB_TAG_W = 10;

    // Tag value at the default width
    typedef logic [BTB_TAG_W-1:0] btb_tag_t;

    // Flush sequencer states
    typedef enum logic [0:0] {
        FLUSH_IDLE  = 1'b0,
        FLUSH_SWEEP = 1'b1
    } flush_state_e;

endpackage : btb_tag_array_pkg
`default_nettype wire

// File: rtl/btb_tag_array_if.sv
`default_nettype none
// ============================================================================
// Module      : btb_tag_array_if
// Description : Lookup / fill / flush bundle of the BTB tag store. The master
//               modport is the fetch-stage side, the slave modport is the
//               tag array.
// Revision    : 1.0 - initial release
// ============================================================================
interface btb_tag_array_if
    import btb_tag_array_pkg::*;
#(
    parameter int WAYS  = BTB_WAYS,
    parameter int SETS  = BTB_SETS,
    parameter int TAG_W = BTB_TAG_W
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int SET_W = $clog2(SETS);

    logic             lookup;
    logic [SET_W-1:0] lookup_set;
    logic [TAG_W-1:0] lookup_tag;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic             load;
    logic [SET_W-1:0] load_set;
    logic [TAG_W-1:0] load_tag;
    logic [WAY_W-1:0] victim_way;
    logic             flush;
    logic             busy;

    modport master (
        output lookup, lookup_set, lookup_tag,
        output load, load_set, load_tag,
        output flush,
        input  hit, hit_way, victim_way, busy
    );

    modport slave (
        input  lookup, lookup_set, lookup_tag,
        input  load, load_set, load_tag,
        input  flush,
        output hit, hit_way, victim_way, busy
    );

endinterface : btb_tag_array_if
`default_nettype wire

// File: rtl/btb_tag_array_plru.sv
`default_nettype none
// ============================================================================
// Module      : btb_plru
// Description : Replacement state for the BTB tag store.
//               BTB_PLRU_EN defined   : tree pseudo-LRU for one set
//                                       (WAYS-1 node bits, heap ordered).
//               BTB_PLRU_EN undefined : one round-robin pointer shared by
//                                       all sets.
// Revision    : 1.0 - initial release
// ============================================================================
module btb_plru #(
    parameter int WAYS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef BTB_PLRU_EN
    input  logic                     clear,
`endif
    input  logic                     access_valid,
    input  logic [$clog2(WAYS)-1:0]  access_way,
    output logic [$clog2(WAYS)-1:0]  victim
);
    localparam int WAY_W = $clog2(WAYS);

`ifdef BTB_PLRU_EN
    // Node n (1..WAYS-1) has children 2n and 2n+1; a 0 points left.
    logic [WAYS-1:1] r_tree;
    logic [WAYS-1:1] w_tree_nxt;
    logic [WAY_W:0]  w_walk;
    logic [WAY_W:0]  w_upd_walk;
    logic [WAY_W-1:0] w_upd_way;

    // Follow the node pointers from the root down to a leaf
    always_comb begin
        w_walk = (WAY_W+1)'(1);
        for (int l = 0; l < WAY_W; l++) begin
            w_walk = {w_walk[WAY_W-1:0], r_tree[w_walk[WAY_W-1:0]]};
        end
        victim = w_walk[WAY_W-1:0];
    end

    // Point every node on the accessed way's path away from that way
    always_comb begin
        w_tree_nxt = r_tree;
        w_upd_walk = (WAY_W+1)'(1);
        w_upd_way  = access_way;
        for (int l = 0; l < WAY_W; l++) begin
            w_tree_nxt[w_upd_walk[WAY_W-1:0]] = ~w_upd_way[WAY_W-1];
            w_upd_walk = {w_upd_walk[WAY_W-1:0], w_upd_way[WAY_W-1]};
            w_upd_way  = w_upd_way << 1;
        end
    end

    // Tree bits: cleared by reset or by the flush sweep of this set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tree <= '0;
        end else if (clear) begin
            r_tree <= '0;
        end else if (access_valid) begin
            r_tree <= w_tree_nxt;
        end
    end
`else
    logic [WAY_W-1:0] r_ptr;

    // Pointer steps past the way just replaced; only a full-set fill calls in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (access_valid) begin
            r_ptr <= access_way + WAY_W'(1);
        end
    end

    assign victim = r_ptr;
`endif

endmodule : btb_plru
`default_nettype wire

// File: rtl/btb_tag_array.sv
`default_nettype none
// ============================================================================
// Module      : btb_tag_array
// Description : WAYS x SETS tag store of the branch target buffer. Registered
//               lookup (hit / hit_way), self-selected fill victim, and a
//               one-set-per-clock flush sweep. Replacement policy is chosen
//               by the BTB_PLRU_EN macro (tree PLRU when defined, global
//               round-robin otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module btb_tag_array
    import btb_tag_array_pkg::*;
#(
    parameter int WAYS  = BTB_WAYS,
    parameter int SETS  = BTB_SETS,
    parameter int TAG_W = BTB_TAG_W
) (
    input  logic           clk,
    input  logic           rst,
    btb_tag_array_if.slave bus
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int SET_W = $clog2(SETS);

    // Storage
    logic [TAG_W-1:0] r_tag   [WAYS][SETS];
    logic [WAYS-1:0]  r_valid [SETS];

    // Flush sequencer
    flush_state_e     r_state;
    flush_state_e     w_state_nxt;
    logic [SET_W-1:0] r_cnt;
    logic [SET_W-1:0] w_cnt_nxt;
    logic             w_sweep;

    // Lookup path
    logic [WAYS-1:0]  w_lk_match;
    logic             w_lk_hit;
    logic [WAY_W-1:0] w_lk_way;
    logic             r_hit;
    logic [WAY_W-1:0] r_hit_way;

    // Fill path
    logic             w_free_any;
    logic [WAY_W-1:0] w_free_way;
    logic [WAY_W-1:0] w_policy_victim;
    logic [WAY_W-1:0] w_victim;
    logic             w_load_en;

    assign w_sweep   = (r_state == FLUSH_SWEEP);
    assign w_load_en = bus.load & ~w_sweep;

    // Tag compare across all ways of the lookup set; lowest matching way wins
    always_comb begin
        w_lk_match = '0;
        w_lk_hit   = 1'b0;
        w_lk_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_lk_match[w] = r_valid[bus.lookup_set][w] &&
                            (r_tag[w][bus.lookup_set] == bus.lookup_tag);
        end
        for (int w = WAYS-1; w >= 0; w--) begin
            if (w_lk_match[w]) begin
                w_lk_hit = 1'b1;
                w_lk_way = WAY_W'(w);
            end
        end
        // A sweeping array reports nothing
        w_lk_hit = w_lk_hit & bus.lookup & ~w_sweep;
        if (!w_lk_hit) begin
            w_lk_way = '0;
        end
    end

    // Victim: lowest invalid way of the fill set, else the replacement policy
    always_comb begin
        w_free_any = 1'b0;
        w_free_way = '0;
        for (int w = WAYS-1; w >= 0; w--) begin
            if (!r_valid[bus.load_set][w]) begin
                w_free_any = 1'b1;
                w_free_way = WAY_W'(w);
            end
        end
        w_victim = w_free_any ? w_free_way : w_policy_victim;
    end

`ifdef BTB_PLRU_EN
    logic [WAY_W-1:0] w_plru_victim [SETS];

    // One tree per set; a same-set fill overrides a same-set hit (fill is MRU)
    for (genvar s = 0; s < SETS; s++) begin : g_plru
        logic             w_acc_v;
        logic [WAY_W-1:0] w_acc_way;

        // Select this set's access for the edge
        always_comb begin
            w_acc_v   = 1'b0;
            w_acc_way = '0;
            if (w_load_en && (bus.load_set == SET_W'(s))) begin
                w_acc_v   = 1'b1;
                w_acc_way = w_victim;
            end else if (w_lk_hit && (bus.lookup_set == SET_W'(s))) begin
                w_acc_v   = 1'b1;
                w_acc_way = w_lk_way;
            end
        end

        btb_plru #(
            .WAYS (WAYS)
        ) u_plru (
            .clk          (clk),
            .rst          (rst),
            .clear        (w_sweep && (r_cnt == SET_W'(s))),
            .access_valid (w_acc_v),
            .access_way   (w_acc_way),
            .victim       (w_plru_victim[s])
        );
    end : g_plru

    assign w_policy_victim = w_plru_victim[bus.load_set];
`else
    // Single shared pointer, consulted and advanced only by full-set fills
    if (1) begin : g_rr
        btb_plru #(
            .WAYS (WAYS)
        ) u_rr (
            .clk          (clk),
            .rst          (rst),
            .access_valid (w_load_en & ~w_free_any),
            .access_way   (w_victim),
            .victim       (w_policy_victim)
        );
    end : g_rr
`endif

    // Tag array write; contents are don't-care until the valid bit is set
    always_ff @(posedge clk) begin
        if (w_load_en) begin
            r_tag[w_victim][bus.load_set] <= bus.load_tag;
        end
    end

    // Valid bits: fill sets one, the sweep clears a whole set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
            end
        end else begin
            if (w_load_en) begin
                r_valid[bus.load_set][w_victim] <= 1'b1;
            end
            if (w_sweep) begin
                r_valid[r_cnt] <= '0;
            end
        end
    end

    // Registered lookup result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit     <= 1'b0;
            r_hit_way <= '0;
        end else begin
            r_hit     <= w_lk_hit;
            r_hit_way <= w_lk_way;
        end
    end

    // Flush FSM state and sweep counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FLUSH_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Flush FSM next state; a flush pulse during the sweep is ignored
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            FLUSH_IDLE: begin
                if (bus.flush) begin
                    w_state_nxt = FLUSH_SWEEP;
                    w_cnt_nxt   = '0;
                end
            end
            FLUSH_SWEEP: begin
                w_cnt_nxt = r_cnt + SET_W'(1);
                if (r_cnt == SET_W'(SETS-1)) begin
                    w_state_nxt = FLUSH_IDLE;
                end
            end
            default: begin
                w_state_nxt = FLUSH_IDLE;
            end
        endcase
    end

    assign bus.hit        = r_hit;
    assign bus.hit_way    = r_hit_way;
    assign bus.victim_way = w_victim;
    assign bus.busy       = w_sweep;

endmodule : btb_tag_array
`default_nettype wire

// File: tb/tb_btb_tag_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_btb_tag_array
// Description : Directed bench for btb_tag_array (WAYS=4, SETS=16, TAG_W=10).
//               Expected replacement choices follow the BTB_PLRU_EN setting.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btb_tag_array;
    import btb_tag_array_pkg::*;

    localparam int WAYS  = 4;
    localparam int SETS  = 16;
    localparam int TAG_W = 10;
`ifdef BTB_PLRU_EN
    localparam bit PLRU = 1'b1;
`else
    localparam bit PLRU = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    int   busy_cycles;

    btb_tag_t pf_tag [5] = '{10'h001, 10'h005, 10'h3FF, 10'h0AA, 10'h155};
    int       pf_set [5] = '{3, 3, 5, 7, 0};

    always #5 clk = ~clk;

    btb_tag_array_if #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) bus ();

    btb_tag_array #(
        .WAYS  (WAYS),
        .SETS  (SETS),
        .TAG_W (TAG_W)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.lookup     = 1'b0;
        bus.lookup_set = '0;
        bus.lookup_tag = '0;
        bus.load       = 1'b0;
        bus.load_set   = '0;
        bus.load_tag   = '0;
        bus.flush      = 1'b0;
    endtask

    task automatic do_load(input int set, input btb_tag_t tag);
        bus.load     = 1'b1;
        bus.load_set = 4'(set);
        bus.load_tag = tag;
        step();
        bus.load     = 1'b0;
    endtask

    task automatic do_lookup(input int set, input btb_tag_t tag);
        bus.lookup     = 1'b1;
        bus.lookup_set = 4'(set);
        bus.lookup_tag = tag;
        step();
        bus.lookup     = 1'b0;
    endtask

    task automatic count_sweep();
        busy_cycles = 0;
        for (int cyc = 0; cyc < 40 && bus.busy; cyc++) begin
            busy_cycles++;
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        bus.load_set = 4'd3;
        #1;
        chk("rst_hit",     32'(bus.hit),        0);
        chk("rst_hit_way", 32'(bus.hit_way),    0);
        chk("rst_busy",    32'(bus.busy),       0);
        chk("rst_victim",  32'(bus.victim_way), 0);
        rst = 1'b0;
        step();

        // Empty array misses
        do_lookup(3, 10'h155);
        chk("empty_miss", 32'(bus.hit), 0);

        // Fill set 3: lowest invalid way each time
        for (int i = 0; i < 4; i++) begin
            bus.load     = 1'b1;
            bus.load_set = 4'd3;
            bus.load_tag = 10'(i + 1);
            #1;
            chk($sformatf("fill3_victim%0d", i), 32'(bus.victim_way), 32'(i));
            step();
        end
        bus.load = 1'b0;
        do_lookup(3, 10'h003);
        chk("set3_hit",     32'(bus.hit),     1);
        chk("set3_hit_way", 32'(bus.hit_way), 2);

        // Set 5: fill, touch way 0, then replace
        for (int i = 0; i < 4; i++) begin
            do_load(5, 10'(16 + i));
        end
        do_lookup(5, 10'h010);
        chk("set5_w0_hit", 32'(bus.hit),     1);
        chk("set5_w0_way", 32'(bus.hit_way), 0);
        bus.load     = 1'b1;
        bus.load_set = 4'd5;
        bus.load_tag = 10'h3FF;
        #1;
        chk("set5_victim", 32'(bus.victim_way), PLRU ? 2 : 0);
        step();
        bus.load = 1'b0;
        do_lookup(5, 10'h010);
        chk("set5_w0_after", 32'(bus.hit), PLRU ? 1 : 0);
        do_lookup(5, 10'h3FF);
        chk("set5_new_hit", 32'(bus.hit),     1);
        chk("set5_new_way", 32'(bus.hit_way), PLRU ? 2 : 0);

        // Full set 3 again: PLRU tree vs advanced shared pointer
        bus.load     = 1'b1;
        bus.load_set = 4'd3;
        bus.load_tag = 10'h005;
        #1;
        chk("set3_victim_full", 32'(bus.victim_way), PLRU ? 0 : 1);
        step();
        bus.load = 1'b0;
        do_lookup(3, 10'h005);
        chk("set3_new_way", 32'(bus.hit_way), PLRU ? 0 : 1);

        // Same-cycle load and lookup: pre-load contents are compared
        bus.load       = 1'b1;
        bus.load_set   = 4'd7;
        bus.load_tag   = 10'h0AA;
        bus.lookup     = 1'b1;
        bus.lookup_set = 4'd7;
        bus.lookup_tag = 10'h0AA;
        step();
        bus.load = 1'b0;
        chk("rbw_miss", 32'(bus.hit), 0);
        step();
        bus.lookup = 1'b0;
        chk("rbw_next_hit", 32'(bus.hit),     1);
        chk("rbw_next_way", 32'(bus.hit_way), 0);

        // Duplicate fill: later lookup reports the lowest way
        bus.load     = 1'b1;
        bus.load_set = 4'd7;
        bus.load_tag = 10'h0AA;
        #1;
        chk("dup_victim", 32'(bus.victim_way), 1);
        step();
        bus.load = 1'b0;
        do_lookup(7, 10'h0AA);
        chk("dup_hit_way", 32'(bus.hit_way), 0);

        // Flush with mid-sweep lookup, dropped load and ignored re-flush
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("flush_busy_rise", 32'(bus.busy), 1);
        busy_cycles = 0;
        for (int cyc = 0; cyc < 40 && bus.busy; cyc++) begin
            busy_cycles++;
            idle();
            if (cyc == 1) begin
                bus.lookup     = 1'b1;
                bus.lookup_set = 4'd3;
                bus.lookup_tag = 10'h001;
            end
            if (cyc == 2) begin
                chk("sweep_lookup_miss", 32'(bus.hit), 0);
            end
            if (cyc == 5) begin
                bus.load     = 1'b1;
                bus.load_set = 4'd0;
                bus.load_tag = 10'h155;
            end
            if (cyc == 8) begin
                bus.flush = 1'b1;
            end
            step();
        end
        idle();
        chk("flush_busy_cycles", 32'(busy_cycles), 16);

        // Everything misses afterwards, including the dropped load
        for (int i = 0; i < 5; i++) begin
            do_lookup(pf_set[i], pf_tag[i]);
            chk($sformatf("post_flush_miss%0d", i), 32'(bus.hit), 0);
        end
        bus.load_set = 4'd3;
        #1;
        chk("post_flush_victim3", 32'(bus.victim_way), 0);

        // Fill set 9 and replace: shared pointer survives the flush
        for (int i = 0; i < 4; i++) begin
            do_load(9, 10'(32 + i));
        end
        bus.load     = 1'b1;
        bus.load_set = 4'd9;
        bus.load_tag = 10'h024;
        #1;
        chk("set9_victim", 32'(bus.victim_way), PLRU ? 0 : 2);
        step();
        bus.load = 1'b0;

        // Reset in the 5th sweep cycle
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        repeat (4) step();
        chk("sweep5_busy", 32'(bus.busy), 1);
        bus.load_set = 4'd9;
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_busy",   32'(bus.busy),       0);
        chk("midrst_hit",    32'(bus.hit),        0);
        chk("midrst_victim", 32'(bus.victim_way), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk("after_rst_idle", 32'(bus.busy), 0);

        // A fresh flush performs a full sweep
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        count_sweep();
        chk("reflush_busy_cycles", 32'(busy_cycles), 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_btb_tag_array
`default_nettype wire
